seq_multiplier_16bit: RTL and testbench
=======================================

// Module: seq_multiplier_16bit
// PURPOSE
//  Sequential shift-add multiplier; the stage directly around the 16-bit two-level CLA adder.
//  Drives the adder's operand/carry-in ports and consumes its sum and carry-out, one partial product per clock.
//  Lets the ALU's MULT operation reuse one shared adder instance.
//  Start/busy/done handshake toward the ALU control unit; 2*WIDTH-bit product held until next start.
// PARAMETERS
//  WIDTH  16  operand width; must match the external adder width; counter is $clog2(WIDTH) bits
// PORTS
//  clk         in   1        single clock, rising edge
//  reset       in   1        synchronous, active-high
//  start       in   1        request; sampled only in IDLE or DONE
//  multiplicand in  WIDTH    latched on accepted start
//  multiplier  in   WIDTH    latched on accepted start
//  add_a       out  WIDTH    to adder in_0: upper product half
//  add_b       out  WIDTH    to adder in_1: multiplicand if multiplier LSB=1, else 0
//  add_cin     out  1        to adder carry_in; constant 0
//  add_sum     in   WIDTH    from adder result
//  add_cout    in   1        from adder carry_out
//  busy        out  1        high in RUN (and NEG)
//  done        out  1        one-cycle pulse; product valid
//  product     out  2*WIDTH  result register {hi,lo}
// BEHAVIOUR
//  Clocking: one clock, clk; reset is synchronous and active-high.
//  Reset: state=IDLE, busy=0, done=0, product=0, count=0, mcand=0; add_a/add_b=0. Reset beats start.
//  States: IDLE, RUN, DONE (+NEG with macro).
//  IDLE: start=1 -> mcand<=multiplicand, hi<=0, lo<=multiplier, count<=0, state->RUN.
//  RUN, each edge: {hi,lo} <= {add_cout, add_sum, lo} >> 1; count++.
//   When count==WIDTH-1 on that edge -> DONE.
//   Exactly WIDTH RUN edges.
//  Adder outputs are valid in RUN only; outside RUN, add_a=0 and add_b=0.
//  Adder is combinational: add_sum/add_cout are used in the same cycle as add_a/add_b.
//  DONE: done=1 for exactly one cycle, busy=0.
//   start=1 -> accepted exactly as in IDLE (back-to-back).
//   Otherwise -> IDLE.
//  Latency: done high in the cycle after the WIDTH-th edge following the start-sampling edge.
//  product is stable from DONE until the next accepted start.
//  Inputs and start while busy=1: ignored; latched operands unaffected.
//  Width rule: add_cout becomes the product MSB before shift; no overflow possible in 2*WIDTH bits.
//  Reset mid-operation: abort immediately to reset values; no done pulse.
// CONFIGURATION
//  SEQ_MULT_SIGNED_EN defined:
//   - Operands are two's complement.
//   - At load, magnitudes are latched; sign = msb(a)^msb(b).
//   - After RUN, if sign=1: enter NEG for one cycle, product <= ~product+1 (internal, not via adder).
//     Else go straight to DONE.
//   - Latency WIDTH+1 when NEG is used.
//   - busy=1 in NEG.
//   - Most-negative operand (0x8000) magnitude is 0x8000 unsigned; result stays correct.
//  SEQ_MULT_SIGNED_EN undefined: unsigned only; no NEG state; latency always WIDTH.
// TESTING
//  1. 0x0003*0x0005 -> product=0x0000000F; done exactly 16 edges after start edge; busy high 16 cycles.
//  2. 0xFFFF*0xFFFF -> 0xFFFE0001 (exercises add_cout path).
//  3. 0x1234*0x0000 -> 0; pulse start and change operands mid-RUN -> ignored, still 0 at done.
//  4. 0x00FF*0x0101, reset at RUN count 7 -> busy=0, product=0, no done.
//     Then 0x0002*0x0004 -> 0x00000008.
//  5. start held during DONE with 0x0007*0x0009 -> new RUN without IDLE gap; done -> 0x0000003F.
//  6. 0xFFFD*0x0005: macro on -> 0xFFFFFFF1, latency 17; macro off -> 0x0004FFF1, latency 16.

Source files
------------

// File: rtl/seq_multiplier_16bit_if.sv
// Start/busy/done handshake and operand/product bus between the ALU control unit
// (master) and the sequential multiplier (slave).
interface seq_multiplier_16bit_if #(
  parameter int unsigned WIDTH = 16
);
  logic                   start;
  logic [WIDTH-1:0]       multiplicand;
  logic [WIDTH-1:0]       multiplier;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/seq_multiplier_16bit.sv
// Sequential shift-add multiplier wrapped around an external combinational WIDTH-bit adder.
// One partial product per clock; WIDTH RUN cycles per operation; product held until next start.
// Optional macro SEQ_MULT_SIGNED_EN: two's-complement operands, magnitudes multiplied, then a
// one-cycle NEG state negates the product when the operand signs differ.
module seq_multiplier_16bit #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  seq_multiplier_16bit_if.slave  bus,
  output logic [WIDTH-1:0]       add_a,
  output logic [WIDTH-1:0]       add_b,
  output logic                   add_cin,
  input  logic [WIDTH-1:0]       add_sum,
  input  logic                   add_cout
);

  localparam int unsigned CntW  = $clog2(WIDTH);
  localparam int unsigned ProdW = 2 * WIDTH;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
`ifdef SEQ_MULT_SIGNED_EN
    StNeg,
`endif
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ProdW:0]   shifted;
  logic [WIDTH-1:0] load_a, load_b;
`ifdef SEQ_MULT_SIGNED_EN
  logic             sign_q, sign_d;
`endif

  // Operand values latched on an accepted start (magnitudes in the signed build).
  always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
    load_a = bus.multiplicand[WIDTH-1] ? (~bus.multiplicand + WIDTH'(1)) : bus.multiplicand;
    load_b = bus.multiplier[WIDTH-1]   ? (~bus.multiplier + WIDTH'(1))   : bus.multiplier;
`else
    load_a = bus.multiplicand;
    load_b = bus.multiplier;
`endif
  end

  // Next-state and datapath: adder carry-out becomes the new MSB before the right shift.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
`ifdef SEQ_MULT_SIGNED_EN
    sign_d  = sign_q;
`endif
    shifted = {add_cout, add_sum, lo_q};
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          mcand_d = load_a;
          hi_d    = '0;
          lo_d    = load_b;
          count_d = '0;
`ifdef SEQ_MULT_SIGNED_EN
          sign_d  = bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
`endif
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        {hi_d, lo_d} = shifted[ProdW:1];
        count_d      = count_q + CntW'(1);
        if (count_q == LastCnt) begin
`ifdef SEQ_MULT_SIGNED_EN
          state_d = sign_q ? StNeg : StDone;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef SEQ_MULT_SIGNED_EN
      StNeg: begin
        {hi_d, lo_d} = ~{hi_q, lo_q} + ProdW'(1);
        state_d      = StDone;
      end
`endif
      default: state_d = StIdle;
    endcase
`ifdef SEQ_MULT_SIGNED_EN
    busy_d = (state_d == StRun) || (state_d == StNeg);
`else
    busy_d = (state_d == StRun);
`endif
    done_d = (state_d == StDone);
  end

  // State register; synchronous reset wins over start and aborts any operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_MULT_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  // Adder operands are only driven while accumulating; zero otherwise.
  always_comb begin
    add_a       = (state_q == StRun) ? hi_q : '0;
    add_b       = ((state_q == StRun) && lo_q[0]) ? mcand_q : '0;
    add_cin     = 1'b0;
    bus.busy    = busy_q;
    bus.done    = done_q;
    bus.product = {hi_q, lo_q};
  end

endmodule

// File: tb/tb_seq_multiplier_16bit.sv
// Directed bench for seq_multiplier_16bit with a behavioural model of the shared adder.
module tb_seq_multiplier_16bit;

  logic        clk;
  logic        reset;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;

  int n_tests = 0;
  int n_fail  = 0;

  seq_multiplier_16bit_if #(.WIDTH(16)) bus ();

  seq_multiplier_16bit #(.WIDTH(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // Combinational adder standing in for the CLA.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'h0, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents operands with start for one edge; returns just after the start-sampling edge.
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
  endtask

  // Counts edges until done (bounded) and busy cycles seen on the way.
  task automatic wait_done(input string tag, output int lat, output int bcyc);
    lat  = 0;
    bcyc = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcyc++;
      tick();
      lat++;
    end
    check_eq({tag, "_done_seen"}, 64'(bus.done), 64'h1);
  endtask

  int   lat, bcyc;
  logic seen_done;

  initial begin
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    reset            = 1'b1;
    repeat (3) tick();
    check_eq("rst_busy", 64'(bus.busy), 64'h0);
    check_eq("rst_done", 64'(bus.done), 64'h0);
    check_eq("rst_product", 64'(bus.product), 64'h0);
    check_eq("rst_add_a", 64'(add_a), 64'h0);
    check_eq("rst_add_b", 64'(add_b), 64'h0);
    check_eq("rst_add_cin", 64'(add_cin), 64'h0);
    reset = 1'b0;
    tick();

    // 1: small product, latency, busy width, done pulse.
    start_op(16'h0003, 16'h0005);
    check_eq("t1_busy_start", 64'(bus.busy), 64'h1);
    check_eq("t1_add_b", 64'(add_b), 64'h3);
    wait_done("t1", lat, bcyc);
    check_eq("t1_latency", 64'(lat), 64'd16);
    check_eq("t1_busy_cycles", 64'(bcyc), 64'd16);
    check_eq("t1_product", 64'(bus.product), 64'h0000000F);
    check_eq("t1_busy_in_done", 64'(bus.busy), 64'h0);
    check_eq("t1_add_a_idle", 64'(add_a), 64'h0);
    check_eq("t1_add_b_idle", 64'(add_b), 64'h0);
    tick();
    check_eq("t1_done_pulse", 64'(bus.done), 64'h0);
    check_eq("t1_product_hold", 64'(bus.product), 64'h0000000F);

    // 2: carry-out path.
    start_op(16'hFFFF, 16'hFFFF);
    wait_done("t2", lat, bcyc);
`ifdef SEQ_MULT_SIGNED_EN
    check_eq("t2_product", 64'(bus.product), 64'h00000001);
`else
    check_eq("t2_product", 64'(bus.product), 64'hFFFE0001);
`endif
    tick();

    // 3: start and operand changes while busy are ignored.
    start_op(16'h1234, 16'h0000);
    repeat (3) tick();
    bus.multiplicand = 16'hFFFF;
    bus.multiplier   = 16'hFFFF;
    bus.start        = 1'b1;
    repeat (2) tick();
    bus.start = 1'b0;
    check_eq("t3_busy_mid", 64'(bus.busy), 64'h1);
    wait_done("t3", lat, bcyc);
    check_eq("t3_product", 64'(bus.product), 64'h0);
    check_eq("t3_latency_rest", 64'(lat), 64'd11);
    tick();

    // 4: reset at count 7 aborts; then a fresh operation.
    start_op(16'h00FF, 16'h0101);
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t4_abort_busy", 64'(bus.busy), 64'h0);
    check_eq("t4_abort_done", 64'(bus.done), 64'h0);
    check_eq("t4_abort_product", 64'(bus.product), 64'h0);
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      seen_done |= bus.done;
      tick();
    end
    check_eq("t4_no_done", 64'(seen_done), 64'h0);
    start_op(16'h0002, 16'h0004);
    wait_done("t4b", lat, bcyc);
    check_eq("t4b_product", 64'(bus.product), 64'h00000008);
    check_eq("t4b_latency", 64'(lat), 64'd16);
    tick();

    // 5: start during DONE restarts without an IDLE cycle.
    start_op(16'h0002, 16'h0003);
    wait_done("t5a", lat, bcyc);
    check_eq("t5a_product", 64'(bus.product), 64'h00000006);
    bus.multiplicand = 16'h0007;
    bus.multiplier   = 16'h0009;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    check_eq("t5_busy_no_gap", 64'(bus.busy), 64'h1);
    check_eq("t5_done_low", 64'(bus.done), 64'h0);
    wait_done("t5b", lat, bcyc);
    check_eq("t5b_latency", 64'(lat), 64'd16);
    check_eq("t5b_product", 64'(bus.product), 64'h0000003F);
    tick();

    // 6: negative multiplicand; 7: most-negative operand.
    start_op(16'hFFFD, 16'h0005);
    wait_done("t6", lat, bcyc);
`ifdef SEQ_MULT_SIGNED_EN
    check_eq("t6_product", 64'(bus.product), 64'hFFFFFFF1);
    check_eq("t6_latency", 64'(lat), 64'd17);
    check_eq("t6_busy_cycles", 64'(bcyc), 64'd17);
`else
    check_eq("t6_product", 64'(bus.product), 64'h0004FFF1);
    check_eq("t6_latency", 64'(lat), 64'd16);
    check_eq("t6_busy_cycles", 64'(bcyc), 64'd16);
`endif
    tick();
    start_op(16'h8000, 16'h0002);
    wait_done("t7", lat, bcyc);
`ifdef SEQ_MULT_SIGNED_EN
    check_eq("t7_product", 64'(bus.product), 64'hFFFF0000);
    check_eq("t7_latency", 64'(lat), 64'd17);
`else
    check_eq("t7_product", 64'(bus.product), 64'h00010000);
    check_eq("t7_latency", 64'(lat), 64'd16);
`endif
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
